note_tracker: RTL and testbench
===============================

NOTE_TRACKER -- requirements
Module: note_tracker

Interface
REQ-001 Parameter TICKS_PER_STEP, default 4: number of accepted tick_in strobes per note_duration increment; legal range 1..255.
REQ-002 Parameter RELEASE_CYCLES, default 4: consecutive synchronized-low samples of the held key needed to end a note; legal range 1..255.
REQ-003 One clock; reset is asynchronous and active-low; ports: clk_in  input  1  system clock, all logic on the rising edge.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 keys_in  input  7  raw piano key levels, bit k high = key k pressed, asynchronous to clk_in.
REQ-006 tick_in  input  1  single-cycle duration timebase strobe, synchronous to clk_in.
REQ-007 key_played  output  3  index 0..6 of the current or last note; feeds color_selector.key_played.
REQ-008 note_duration  output  3  quantized hold time 0..7 of the current or last note; feeds color_selector.note_duration.
REQ-009 note_active  output  1  high while a note is held, including release-pending cycles.
REQ-010 note_start  output  1  one-cycle pulse when a note begins.
REQ-011 note_end  output  1  one-cycle pulse when a note ends.

Function
REQ-012 The block SHALL pass each keys_in bit through a two-flop synchronizer; every other rule uses only synchronized values (syn).
REQ-013 The state machine SHALL have exactly two states: IDLE and HELD.
REQ-014 In IDLE with syn nonzero, the block SHALL load key_played with the lowest set index, clear note_duration, tick count and release count, pulse note_start, set note_active and go to HELD, all at one edge.
REQ-015 Latency: keys_in high before edge E SHALL produce note_start, note_active and the new key_played registered at edge E+2.
REQ-016 In HELD, syn bits other than key_played SHALL be ignored.
REQ-017 In HELD with syn[key_played] high, the release count SHALL clear, and each tick_in SHALL increment the tick count.
REQ-018 When a tick_in arrives with tick count equal to TICKS_PER_STEP-1, the tick count SHALL clear and note_duration SHALL increment, saturating at 7; ticks still clear the tick count at saturation.
REQ-019 In HELD with syn[key_played] low, the release count SHALL increment and tick_in SHALL be ignored.
REQ-020 If the held key goes high again before the release count reaches RELEASE_CYCLES, the release count SHALL clear and counting SHALL resume from the retained tick count and duration.
REQ-021 At the edge where the release count reaches RELEASE_CYCLES, the block SHALL pulse note_end, clear note_active and return to IDLE.
REQ-022 With RELEASE_CYCLES=4, keys_in falling before edge E SHALL give note_end at edge E+5.
REQ-023 key_played and note_duration SHALL hold their last values in IDLE until the next note_start.
REQ-024 After note_end, a new note SHALL start no earlier than the next edge (minimum one IDLE cycle), even if another key is already high.
REQ-025 note_start and note_end SHALL never be high in the same cycle.
REQ-026 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 While rst_in is low, synchronizer flops, state (IDLE), counters and all outputs SHALL be 0, regardless of clk_in.
REQ-028 Reset asserted mid-note SHALL clear immediately with no note_end pulse.
REQ-029 After rst_in deasserts, a key already high SHALL start a note by the normal synchronizer latency (REQ-015).

Verification
REQ-030 Press key 3 alone before edge E, no ticks -> note_start at E+2, key_played=3, note_duration=0, note_active=1.
REQ-031 Hold key 2 with tick_in every 10 cycles for 40 ticks (defaults) -> note_duration steps 1..7 at ticks 4,8,...,28, then stays 7.
REQ-032 Press keys 5 and 1 together, then release key 5 only -> key_played=1; no note_end; key 5 activity ignored.
REQ-033 Hold key 0 for 8 ticks, drop it low for 2 cycles, then high again, 4 more ticks -> no note_end, note_duration=3.
REQ-034 Release the held key before edge E -> note_end at E+5, note_active=0, key_played and note_duration unchanged; key 6 already high -> note_start one cycle after note_end.
REQ-035 Assert rst_in low mid-note with note_duration=5 -> all outputs 0 asynchronously, no note_end pulse.

Source files
------------

// File: rtl/note_tracker.sv
// note_tracker: follows a single held piano key and reports which key
// started the note, how long it has been held (in TICKS_PER_STEP units,
// saturating at 7), and one-cycle start/end strobes. Key inputs are
// asynchronous and pass through a two-flop synchronizer first. A note ends
// only after the held key reads low for RELEASE_CYCLES consecutive cycles.
module note_tracker #(
    parameter int TICKS_PER_STEP = 4,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [6:0] keys_in,
    input  logic       tick_in,
    output logic [2:0] key_played,
    output logic [2:0] note_duration,
    output logic       note_active,
    output logic       note_start,
    output logic       note_end
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_STEP - 1);
    localparam logic [7:0] REL_LAST  = 8'(RELEASE_CYCLES - 1);

    state_t     state_r;
    state_t     state_s;
    logic [6:0] sync1_r;
    logic [6:0] sync2_r;
    logic [7:0] tick_cnt_r;
    logic [7:0] tick_cnt_s;
    logic [7:0] rel_cnt_r;
    logic [7:0] rel_cnt_s;
    logic [2:0] key_s;
    logic [2:0] dur_s;
    logic       active_s;
    logic       start_s;
    logic       end_s;

    // Lowest set key index wins when several keys arrive together.
    function automatic logic [2:0] lowest_index(input logic [6:0] v);
        logic [2:0] idx;
        casez (v)
            7'b??????1: idx = 3'd0;
            7'b?????10: idx = 3'd1;
            7'b????100: idx = 3'd2;
            7'b???1000: idx = 3'd3;
            7'b??10000: idx = 3'd4;
            7'b?100000: idx = 3'd5;
            7'b1000000: idx = 3'd6;
            default:    idx = 3'd0;
        endcase
        return idx;
    endfunction

    // Two-flop synchronizer for the asynchronous key levels.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_r <= 7'd0;
            sync2_r <= 7'd0;
        end else begin
            sync1_r <= keys_in;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, counter and output decode for the IDLE/HELD machine.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        rel_cnt_s  = rel_cnt_r;
        key_s      = key_played;
        dur_s      = note_duration;
        active_s   = note_active;
        start_s    = 1'b0;
        end_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync2_r != 7'd0) begin
                    state_s    = HELD;
                    key_s      = lowest_index(sync2_r);
                    dur_s      = 3'd0;
                    tick_cnt_s = 8'd0;
                    rel_cnt_s  = 8'd0;
                    start_s    = 1'b1;
                    active_s   = 1'b1;
                end else begin
                    active_s   = 1'b0;
                end
            end
            HELD: begin
                if (sync2_r[key_played]) begin
                    // Key still down: any pending release is cancelled.
                    rel_cnt_s = 8'd0;
                    if (tick_in) begin
                        if (tick_cnt_r == TICK_LAST) begin
                            tick_cnt_s = 8'd0;
                            if (note_duration != 3'd7) begin
                                dur_s = note_duration + 3'd1;
                            end else begin
                                dur_s = note_duration;
                            end
                        end else begin
                            tick_cnt_s = tick_cnt_r + 8'd1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r;
                    end
                end else begin
                    // Key reads low: ticks are ignored while release is pending.
                    if (rel_cnt_r == REL_LAST) begin
                        rel_cnt_s = 8'd0;
                        end_s     = 1'b1;
                        active_s  = 1'b0;
                        state_s   = IDLE;
                    end else begin
                        rel_cnt_s = rel_cnt_r + 8'd1;
                    end
                end
            end
            default: begin
                state_s  = IDLE;
                active_s = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs are registered here.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r       <= IDLE;
            tick_cnt_r    <= 8'd0;
            rel_cnt_r     <= 8'd0;
            key_played    <= 3'd0;
            note_duration <= 3'd0;
            note_active   <= 1'b0;
            note_start    <= 1'b0;
            note_end      <= 1'b0;
        end else begin
            state_r       <= state_s;
            tick_cnt_r    <= tick_cnt_s;
            rel_cnt_r     <= rel_cnt_s;
            key_played    <= key_s;
            note_duration <= dur_s;
            note_active   <= active_s;
            note_start    <= start_s;
            note_end      <= end_s;
        end
    end

endmodule

// File: tb/tb_note_tracker.sv
// Bench for note_tracker: a behavioural reference model predicts note
// start/end events into a queue; a monitor on the falling edge pops and
// compares them against the DUT strobes and tracks the steady outputs.
module tb_note_tracker;

    localparam int TPS = 4;
    localparam int RC  = 4;

    logic       clk_in  = 1'b0;
    logic       rst_in  = 1'b0;
    logic [6:0] keys_in = 7'd0;
    logic       tick_in = 1'b0;
    logic [2:0] key_played;
    logic [2:0] note_duration;
    logic       note_active;
    logic       note_start;
    logic       note_end;

    note_tracker dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .keys_in       (keys_in),
        .tick_in       (tick_in),
        .key_played    (key_played),
        .note_duration (note_duration),
        .note_active   (note_active),
        .note_start    (note_start),
        .note_end      (note_end)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       is_start;
        bit [2:0] key;
        bit [2:0] dur;
    } ev_t;

    ev_t        exp_q[$];
    logic [6:0] m_s1 = 7'd0;
    logic [6:0] m_s2 = 7'd0;
    bit         m_active = 1'b0;
    bit [2:0]   m_key = 3'd0;
    bit [2:0]   m_dur = 3'd0;
    int         m_ticks = 0;
    int         m_low = 0;

    initial begin
        forever begin
            @(posedge clk_in or negedge rst_in);
            if (!rst_in) begin
                m_s1 = 7'd0; m_s2 = 7'd0;
                m_active = 1'b0; m_key = 3'd0; m_dur = 3'd0;
                m_ticks = 0; m_low = 0;
                exp_q.delete();
            end else begin
                logic [6:0] syn;
                ev_t e;
                syn  = m_s2;
                m_s2 = m_s1;
                m_s1 = keys_in;
                if (!m_active) begin
                    if (syn != 7'd0) begin
                        bit found;
                        found = 1'b0;
                        for (int k = 0; k < 7; k++) begin
                            if (syn[k] && !found) begin
                                m_key = 3'(k);
                                found = 1'b1;
                            end
                        end
                        m_ticks = 0; m_low = 0; m_dur = 3'd0; m_active = 1'b1;
                        e.is_start = 1'b1; e.key = m_key; e.dur = 3'd0;
                        exp_q.push_back(e);
                    end
                end else begin
                    if (syn[m_key]) begin
                        m_low = 0;
                        if (tick_in) m_ticks++;
                    end else begin
                        m_low++;
                        if (m_low == RC) begin
                            m_active = 1'b0;
                            e.is_start = 1'b0; e.key = m_key; e.dur = m_dur;
                            exp_q.push_back(e);
                        end
                    end
                    if (m_active) m_dur = (m_ticks / TPS > 7) ? 3'd7 : 3'(m_ticks / TPS);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                chk("rst_key", key_played, 0);
                chk("rst_dur", note_duration, 0);
                chk("rst_active", note_active, 0);
                chk("rst_start", note_start, 0);
                chk("rst_end", note_end, 0);
            end else begin
                chk("start_end_overlap", note_start & note_end, 0);
                if (exp_q.size() > 0) begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.is_start) begin
                        chk("start_pulse", note_start, 1);
                        chk("start_key", key_played, e.key);
                    end else begin
                        chk("end_pulse", note_end, 1);
                        chk("end_key", key_played, e.key);
                        chk("end_dur", note_duration, e.dur);
                    end
                end else begin
                    chk("spurious_start", note_start, 0);
                    chk("spurious_end", note_end, 0);
                end
                chk("active", note_active, m_active);
                chk("dur", note_duration, m_dur);
                chk("key", key_played, m_key);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cycles(3);
        rst_in = 1'b1;
        cycles(2);

        // Single key 3, no ticks: start exactly two edges after press.
        keys_in = 7'h08;
        cycles(2);
        chk("r030_not_early", note_start, 0);
        cycles(1);
        chk("r030_start", note_start, 1);
        chk("r030_key", key_played, 3);
        chk("r030_dur", note_duration, 0);
        chk("r030_active", note_active, 1);
        keys_in = 7'h00;
        cycles(10);

        // Key 2 held, a tick every 10 cycles for 40 ticks: duration saturates.
        keys_in = 7'h04;
        cycles(4);
        for (int t = 0; t < 40; t++) begin
            tick_in = 1'b1;
            cycles(1);
            tick_in = 1'b0;
            cycles(9);
            if (t == 11) chk("r031_dur_after12", note_duration, 3);
        end
        chk("r031_dur_sat", note_duration, 7);
        keys_in = 7'h00;
        cycles(10);

        // Keys 5 and 1 together, then key 5 toggles: key 1 holds the note.
        keys_in = 7'h22;
        cycles(5);
        keys_in = 7'h02;
        cycles(6);
        keys_in = 7'h22;
        cycles(3);
        keys_in = 7'h02;
        cycles(6);
        chk("r032_key", key_played, 1);
        chk("r032_active", note_active, 1);
        keys_in = 7'h00;
        cycles(10);

        // Key 0: 8 ticks, 2-cycle dropout, 4 more ticks -> duration 3.
        keys_in = 7'h01;
        cycles(4);
        for (int t = 0; t < 8; t++) begin
            tick_in = 1'b1; cycles(1); tick_in = 1'b0; cycles(1);
        end
        keys_in = 7'h00;
        cycles(2);
        keys_in = 7'h01;
        cycles(4);
        for (int t = 0; t < 4; t++) begin
            tick_in = 1'b1; cycles(1); tick_in = 1'b0; cycles(1);
        end
        cycles(2);
        chk("r033_dur", note_duration, 3);
        chk("r033_active", note_active, 1);

        // Key 6 rises while key 0 held; release key 0 -> end at E+5, then key 6.
        keys_in = 7'h41;
        cycles(4);
        keys_in = 7'h40;
        cycles(5);
        chk("r034_not_early", note_end, 0);
        cycles(1);
        chk("r034_end", note_end, 1);
        chk("r034_active", note_active, 0);
        chk("r034_key", key_played, 0);
        chk("r034_dur", note_duration, 3);
        cycles(1);
        chk("r034_next_start", note_start, 1);
        chk("r034_next_key", key_played, 6);
        keys_in = 7'h00;
        cycles(10);

        // Key 4 to duration 5, then asynchronous reset mid-note.
        keys_in = 7'h10;
        cycles(4);
        tick_in = 1'b1;
        cycles(20);
        tick_in = 1'b0;
        cycles(1);
        chk("r035_dur_pre", note_duration, 5);
        #2 rst_in = 1'b0;
        #1;
        chk("r035_key", key_played, 0);
        chk("r035_dur", note_duration, 0);
        chk("r035_active", note_active, 0);
        chk("r035_end", note_end, 0);
        chk("r035_start", note_start, 0);
        cycles(3);
        rst_in = 1'b1;
        cycles(3);
        chk("r029_restart", note_start, 1);
        chk("r029_key", key_played, 4);
        keys_in = 7'h00;
        cycles(10);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0) keys_in = 7'h00;
                else keys_in = 7'($urandom_range(1, 127));
            end
            tick_in = ($urandom_range(0, 2) == 0);
            if (rst_in == 1'b0) rst_in = 1'b1;
            else if ($urandom_range(0, 999) == 0) rst_in = 1'b0;
            cycles(1);
        end
        rst_in  = 1'b1;
        keys_in = 7'h00;
        tick_in = 1'b0;
        cycles(12);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_idle", note_active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
